// File: rtl/rob_mp_queue.sv
// Reorder buffer: circular queue with in-order alloc/commit and out-of-order multi-port writeback.
// Optional macro ROB_WB_BYPASS_EN forwards same-cycle writebacks to the two lookup ports.
module rob_mp_queue #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned WB_PORTS = 2,
    parameter int unsigned XLEN     = 32,
    localparam int unsigned TAG_W   = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      alloc_valid_i,
    input  logic [4:0]                alloc_rd_i,
    output logic                      alloc_ready_o,
    output logic [TAG_W-1:0]          alloc_tag_o,
    input  logic [WB_PORTS-1:0]       wb_valid_i,
    input  logic [WB_PORTS*TAG_W-1:0] wb_tag_i,
    input  logic [WB_PORTS*XLEN-1:0]  wb_value_i,
    output logic                      commit_valid_o,
    input  logic                      commit_ready_i,
    output logic [4:0]                commit_rd_o,
    output logic                      commit_we_o,
    output logic [XLEN-1:0]           commit_value_o,
    output logic [TAG_W-1:0]          commit_tag_o,
    input  logic [2*TAG_W-1:0]        lk_tag_i,
    output logic [1:0]                lk_ready_o,
    output logic [2*XLEN-1:0]         lk_value_o,
    output logic [TAG_W:0]            count_o
);
    localparam logic [TAG_W:0] PtrOne = (TAG_W+1)'(1);

    logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
    logic [4:0]       rd_q    [DEPTH];
    logic [4:0]       rd_d    [DEPTH];
    logic [XLEN-1:0]  value_q [DEPTH];
    logic [XLEN-1:0]  value_d [DEPTH];
    logic [TAG_W:0]   head_q, head_d, tail_q, tail_d;
    logic [TAG_W-1:0] head_idx, tail_idx;
    logic             full, alloc_fire, commit_fire;

    logic [TAG_W-1:0] wb_tag [WB_PORTS];
    logic [XLEN-1:0]  wb_val [WB_PORTS];

    for (genvar p = 0; p < WB_PORTS; p++) begin : g_wb
        assign wb_tag[p] = wb_tag_i[p*TAG_W +: TAG_W];
        assign wb_val[p] = wb_value_i[p*XLEN +: XLEN];
    end

    assign head_idx = head_q[TAG_W-1:0];
    assign tail_idx = tail_q[TAG_W-1:0];
    // Wrap bit distinguishes full from empty when indices coincide.
    assign full     = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
    assign count_o  = tail_q - head_q;

    assign alloc_ready_o  = !full;
    assign alloc_tag_o    = tail_idx;
    assign commit_valid_o = valid_q[head_idx] && done_q[head_idx];
    assign commit_rd_o    = rd_q[head_idx];
    assign commit_value_o = value_q[head_idx];
    assign commit_tag_o   = head_idx;
    assign commit_we_o    = commit_valid_o && (commit_rd_o != 5'd0);

    assign alloc_fire  = alloc_valid_i && !full;
    assign commit_fire = commit_valid_o && commit_ready_i;

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        rd_d    = rd_q;
        value_d = value_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush_i) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            // Walk ports high to low so the lowest-indexed port is applied last and wins.
            for (int p = int'(WB_PORTS) - 1; p >= 0; p--) begin
                if (wb_valid_i[p] && valid_q[wb_tag[p]]) begin
                    done_d[wb_tag[p]]  = 1'b1;
                    value_d[wb_tag[p]] = wb_val[p];
                end
            end
            if (commit_fire) begin
                valid_d[head_idx] = 1'b0;
                done_d[head_idx]  = 1'b0;
                head_d            = head_q + PtrOne;
            end
            if (alloc_fire) begin
                valid_d[tail_idx] = 1'b1;
                done_d[tail_idx]  = 1'b0;
                rd_d[tail_idx]    = alloc_rd_i;
                value_d[tail_idx] = '0;
                tail_d            = tail_q + PtrOne;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                rd_q[i]    <= '0;
                value_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            rd_q    <= rd_d;
            value_q <= value_d;
        end
    end

    for (genvar l = 0; l < 2; l++) begin : g_lk
        logic [TAG_W-1:0] tag;
        logic             rdy;
        logic [XLEN-1:0]  val;

        assign tag = lk_tag_i[l*TAG_W +: TAG_W];

        always_comb begin
            rdy = valid_q[tag] && done_q[tag];
            val = rdy ? value_q[tag] : '0;
`ifdef ROB_WB_BYPASS_EN
            for (int p = int'(WB_PORTS) - 1; p >= 0; p--) begin
                if (valid_q[tag] && wb_valid_i[p] && (wb_tag[p] == tag)) begin
                    rdy = 1'b1;
                    val = wb_val[p];
                end
            end
`endif
        end

        assign lk_ready_o[l]              = rdy;
        assign lk_value_o[l*XLEN +: XLEN] = val;
    end

endmodule

// File: tb/tb_rob_mp_queue.sv
// Self-checking bench for rob_mp_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_rob_mp_queue;
    localparam int DEPTH = 8;
    localparam int WBP   = 2;
    localparam int XLEN  = 32;
    localparam int TW    = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              alloc_valid = 1'b0;
    logic [4:0]        alloc_rd = '0;
    logic              alloc_ready;
    logic [TW-1:0]     alloc_tag;
    logic [WBP-1:0]    wb_valid = '0;
    logic [WBP*TW-1:0] wb_tag = '0;
    logic [WBP*XLEN-1:0] wb_value = '0;
    logic              commit_valid;
    logic              commit_ready = 1'b0;
    logic [4:0]        commit_rd;
    logic              commit_we;
    logic [XLEN-1:0]   commit_value;
    logic [TW-1:0]     commit_tag;
    logic [2*TW-1:0]   lk_tag = '0;
    logic [1:0]        lk_ready;
    logic [2*XLEN-1:0] lk_value;
    logic [TW:0]       count;

    int n_checks = 0;
    int n_fail   = 0;

    rob_mp_queue #(.DEPTH(DEPTH), .WB_PORTS(WBP), .XLEN(XLEN)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush),
        .alloc_valid_i  (alloc_valid),
        .alloc_rd_i     (alloc_rd),
        .alloc_ready_o  (alloc_ready),
        .alloc_tag_o    (alloc_tag),
        .wb_valid_i     (wb_valid),
        .wb_tag_i       (wb_tag),
        .wb_value_i     (wb_value),
        .commit_valid_o (commit_valid),
        .commit_ready_i (commit_ready),
        .commit_rd_o    (commit_rd),
        .commit_we_o    (commit_we),
        .commit_value_o (commit_value),
        .commit_tag_o   (commit_tag),
        .lk_tag_i       (lk_tag),
        .lk_ready_o     (lk_ready),
        .lk_value_o     (lk_value),
        .count_o        (count)
    );

    always #5 clk = ~clk;

    // Reference model: per-tag entry arrays plus a program-order queue of live tags.
    bit           m_valid [DEPTH];
    bit           m_done  [DEPTH];
    logic [4:0]   m_rd    [DEPTH];
    logic [31:0]  m_val   [DEPTH];
    int           m_order [$];
    int           m_next;

    task automatic model_reset();
        foreach (m_valid[i]) begin
            m_valid[i] = 0;
            m_done[i]  = 0;
            m_rd[i]    = '0;
            m_val[i]   = '0;
        end
        m_order.delete();
        m_next = 0;
    endtask

    task automatic model_step();
        bit hit [DEPTH];
        bit cv;
        bit af;
        if (flush) begin
            model_reset();
            return;
        end
        cv = (m_order.size() > 0) && m_done[m_order[0]];
        af = alloc_valid && (m_order.size() < DEPTH);
        foreach (hit[i]) hit[i] = 0;
        for (int p = 0; p < WBP; p++) begin
            int t = int'(wb_tag[p*TW +: TW]);
            if (wb_valid[p] && m_valid[t] && !hit[t]) begin
                hit[t]   = 1;
                m_done[t] = 1;
                m_val[t]  = wb_value[p*XLEN +: XLEN];
            end
        end
        if (cv && commit_ready) begin
            m_valid[m_order[0]] = 0;
            m_done[m_order[0]]  = 0;
            void'(m_order.pop_front());
        end
        if (af) begin
            m_valid[m_next] = 1;
            m_done[m_next]  = 0;
            m_rd[m_next]    = alloc_rd;
            m_val[m_next]   = '0;
            m_order.push_back(m_next);
            m_next = (m_next + 1) % DEPTH;
        end
    endtask

    function automatic void exp_lk(input int t, output bit r, output logic [31:0] v);
        r = m_valid[t] && m_done[t];
        v = r ? m_val[t] : 32'h0;
`ifdef ROB_WB_BYPASS_EN
        if (m_valid[t]) begin
            for (int p = 0; p < WBP; p++) begin
                if (wb_valid[p] && int'(wb_tag[p*TW +: TW]) == t) begin
                    r = 1;
                    v = wb_value[p*XLEN +: XLEN];
                    break;
                end
            end
        end
`endif
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush        = 1'b0;
        alloc_valid  = 1'b0;
        alloc_rd     = '0;
        wb_valid     = '0;
        wb_tag       = '0;
        wb_value     = '0;
        commit_ready = 1'b0;
        lk_tag       = '0;
    endtask

    task automatic set_wb(input int p, input int t, input logic [31:0] v);
        wb_valid[p]            = 1'b1;
        wb_tag[p*TW +: TW]     = TW'(t);
        wb_value[p*XLEN +: XLEN] = v;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic alloc_n(input int n, input int rd0);
        for (int i = 0; i < n; i++) begin
            alloc_valid = 1'b1;
            alloc_rd    = 5'(rd0 + i);
            tick();
        end
        alloc_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        lk_tag = {3'd1, 3'd0};
        #1;
        n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset alloc_ready got %b want 1", alloc_ready); end
        n_checks++; if (alloc_tag !== 3'd0) begin n_fail++; $display("FAIL reset alloc_tag got %0d want 0", alloc_tag); end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset count got %0d want 0", count); end
        n_checks++; if (commit_valid !== 1'b0 || commit_we !== 1'b0) begin n_fail++; $display("FAIL reset commit got v=%b we=%b want 0 0", commit_valid, commit_we); end
        n_checks++; if (lk_ready !== 2'b00 || lk_value !== 64'h0) begin n_fail++; $display("FAIL reset lookup got rdy=%b val=%h want 0 0", lk_ready, lk_value); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            alloc_valid = 1'b1;
            alloc_rd    = 5'(i + 1);
            #1;
            n_checks++; if (alloc_tag !== TW'(i)) begin n_fail++; $display("FAIL fill alloc_tag got %0d want %0d", alloc_tag, i); end
            tick();
        end
        n_checks++; if (alloc_ready !== 1'b0 || count !== 4'd8) begin n_fail++; $display("FAIL fill full got rdy=%b cnt=%0d want 0 8", alloc_ready, count); end
        alloc_rd = 5'd9;
        tick();
        alloc_valid = 1'b0;
        n_checks++; if (count !== 4'd8 || alloc_tag !== 3'd0) begin n_fail++; $display("FAIL fill drop got cnt=%0d tag=%0d want 8 0", count, alloc_tag); end
    endtask

    task automatic test_wb_order();
        set_wb(1, 2, 32'hBEEF);
        tick();
        wb_valid = '0;
        #1;
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL order head-not-done commit_valid got %b want 0", commit_valid); end
        set_wb(0, 0, 32'hA0);
        set_wb(1, 1, 32'hA1);
        tick();
        wb_valid     = '0;
        commit_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (commit_valid !== 1'b1 || commit_rd !== 5'(k + 1) || commit_tag !== TW'(k)) begin
                n_fail++; $display("FAIL order commit %0d got v=%b rd=%0d tag=%0d want 1 %0d %0d", k, commit_valid, commit_rd, commit_tag, k + 1, k);
            end
            if (k == 2) begin
                n_checks++; if (commit_value !== 32'hBEEF) begin n_fail++; $display("FAIL order value got %h want BEEF", commit_value); end
            end
            tick();
        end
        commit_ready = 1'b0;
        n_checks++; if (count !== 4'd5 || commit_valid !== 1'b0) begin n_fail++; $display("FAIL order after got cnt=%0d v=%b want 5 0", count, commit_valid); end
    endtask

    task automatic test_same_tag();
        set_wb(0, 3, 32'h11);
        set_wb(1, 3, 32'h22);
        tick();
        wb_valid = '0;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if (commit_valid !== 1'b1 || commit_value !== 32'h11 || commit_rd !== 5'd4 || commit_tag !== 3'd3) begin
                n_fail++; $display("FAIL same_tag hold%0d got v=%b val=%h rd=%0d want 1 11 4", k, commit_valid, commit_value, commit_rd);
            end
            tick();
        end
    endtask

    task automatic test_full_alloc_commit();
        do_reset();
        alloc_n(DEPTH, 1);
        set_wb(0, 0, 32'h7);
        tick();
        wb_valid     = '0;
        alloc_valid  = 1'b1;
        alloc_rd     = 5'd9;
        commit_ready = 1'b1;
        #1;
        n_checks++; if (alloc_ready !== 1'b0 || commit_valid !== 1'b1) begin n_fail++; $display("FAIL full_ac pre got rdy=%b cv=%b want 0 1", alloc_ready, commit_valid); end
        tick();
        commit_ready = 1'b0;
        n_checks++; if (count !== 4'd7 || alloc_ready !== 1'b1 || alloc_tag !== 3'd0) begin n_fail++; $display("FAIL full_ac pop got cnt=%0d rdy=%b tag=%0d want 7 1 0", count, alloc_ready, alloc_tag); end
        tick();
        alloc_valid = 1'b0;
        n_checks++; if (count !== 4'd8 || alloc_tag !== 3'd1 || commit_tag !== 3'd1) begin n_fail++; $display("FAIL full_ac wrap got cnt=%0d tag=%0d head=%0d want 8 1 1", count, alloc_tag, commit_tag); end
    endtask

    task automatic test_flush();
        do_reset();
        alloc_n(5, 1);
        flush       = 1'b1;
        alloc_valid = 1'b1;
        set_wb(0, 0, 32'h99);
        tick();
        clear_inputs();
        #1;
        n_checks++; if (count !== 4'd0 || commit_valid !== 1'b0 || alloc_tag !== 3'd0) begin n_fail++; $display("FAIL flush got cnt=%0d cv=%b tag=%0d want 0 0 0", count, commit_valid, alloc_tag); end
        n_checks++; if (lk_ready[0] !== 1'b0 || alloc_ready !== 1'b1) begin n_fail++; $display("FAIL flush lookup got rdy=%b ar=%b want 0 1", lk_ready[0], alloc_ready); end
    endtask

    task automatic test_lookup_bypass();
        do_reset();
        alloc_n(5, 0);
        lk_tag = {3'd1, 3'd4};
        set_wb(0, 4, 32'h55);
        #1;
`ifdef ROB_WB_BYPASS_EN
        n_checks++; if (lk_ready[0] !== 1'b1 || lk_value[31:0] !== 32'h55) begin n_fail++; $display("FAIL lookup same-cycle got rdy=%b val=%h want 1 55", lk_ready[0], lk_value[31:0]); end
`else
        n_checks++; if (lk_ready[0] !== 1'b0 || lk_value[31:0] !== 32'h0) begin n_fail++; $display("FAIL lookup same-cycle got rdy=%b val=%h want 0 0", lk_ready[0], lk_value[31:0]); end
`endif
        n_checks++; if (lk_ready[1] !== 1'b0 || lk_value[63:32] !== 32'h0) begin n_fail++; $display("FAIL lookup port1 got rdy=%b val=%h want 0 0", lk_ready[1], lk_value[63:32]); end
        tick();
        wb_valid = '0;
        #1;
        n_checks++; if (lk_ready[0] !== 1'b1 || lk_value[31:0] !== 32'h55) begin n_fail++; $display("FAIL lookup next-cycle got rdy=%b val=%h want 1 55", lk_ready[0], lk_value[31:0]); end
        set_wb(0, 0, 32'h66);
        #1;
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL rd0 wb-same-cycle commit_valid got %b want 0", commit_valid); end
        tick();
        wb_valid = '0;
        #1;
        n_checks++; if (commit_valid !== 1'b1 || commit_we !== 1'b0 || commit_rd !== 5'd0) begin n_fail++; $display("FAIL rd0 commit got v=%b we=%b rd=%0d want 1 0 0", commit_valid, commit_we, commit_rd); end
    endtask

    task automatic test_async_reset();
        do_reset();
        alloc_n(3, 1);
        set_wb(0, 0, 32'h5);
        tick();
        wb_valid = '0;
        #2;
        n_checks++; if (commit_valid !== 1'b1 || count !== 4'd3) begin n_fail++; $display("FAIL async pre got cv=%b cnt=%0d want 1 3", commit_valid, count); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (commit_valid !== 1'b0 || count !== 4'd0 || alloc_tag !== 3'd0) begin n_fail++; $display("FAIL async reset got cv=%b cnt=%0d tag=%0d want 0 0 0", commit_valid, count, alloc_tag); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        bit          er;
        logic [31:0] ev;
        int          h;
        bit          ecv;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            alloc_valid  = ($urandom_range(0, 9) < 6);
            alloc_rd     = 5'($urandom);
            commit_ready = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 59) == 0);
            for (int p = 0; p < WBP; p++) begin
                int t;
                if (m_order.size() > 0 && $urandom_range(0, 3) != 0)
                    t = m_order[$urandom_range(0, m_order.size() - 1)];
                else
                    t = $urandom_range(0, DEPTH - 1);
                wb_valid[p]              = ($urandom_range(0, 2) == 0);
                wb_tag[p*TW +: TW]       = TW'(t);
                wb_value[p*XLEN +: XLEN] = $urandom;
            end
            lk_tag = (2*TW)'($urandom);
            #1;
            h   = (m_order.size() > 0) ? m_order[0] : m_next;
            ecv = (m_order.size() > 0) && m_done[h];
            n_checks++; if (alloc_ready !== (m_order.size() < DEPTH)) begin n_fail++; $display("FAIL rand alloc_ready cyc %0d got %b want %b", c, alloc_ready, m_order.size() < DEPTH); end
            n_checks++; if (alloc_tag !== TW'(m_next)) begin n_fail++; $display("FAIL rand alloc_tag cyc %0d got %0d want %0d", c, alloc_tag, m_next); end
            n_checks++; if (count !== (TW+1)'(m_order.size())) begin n_fail++; $display("FAIL rand count cyc %0d got %0d want %0d", c, count, m_order.size()); end
            n_checks++; if (commit_valid !== ecv) begin n_fail++; $display("FAIL rand commit_valid cyc %0d got %b want %b", c, commit_valid, ecv); end
            n_checks++; if (commit_we !== (ecv && m_rd[h] != 0)) begin n_fail++; $display("FAIL rand commit_we cyc %0d got %b want %b", c, commit_we, ecv && m_rd[h] != 0); end
            if (ecv) begin
                n_checks++;
                if (commit_rd !== m_rd[h] || commit_value !== m_val[h] || commit_tag !== TW'(h)) begin
                    n_fail++; $display("FAIL rand commit cyc %0d got rd=%0d val=%h tag=%0d want %0d %h %0d", c, commit_rd, commit_value, commit_tag, m_rd[h], m_val[h], h);
                end
            end
            for (int l = 0; l < 2; l++) begin
                exp_lk(int'(lk_tag[l*TW +: TW]), er, ev);
                n_checks++;
                if (lk_ready[l] !== er || lk_value[l*XLEN +: XLEN] !== ev) begin
                    n_fail++; $display("FAIL rand lookup%0d cyc %0d got rdy=%b val=%h want %b %h", l, c, lk_ready[l], lk_value[l*XLEN +: XLEN], er, ev);
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_wb_order();
        test_same_tag();
        test_full_alloc_commit();
        test_flush();
        test_lookup_bypass();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
